microwave_cook_controller: RTL and testbench

- Top-level sequencer for the toy microwave: accepts keypad time entry, start/stop buttons and the door switch.
- Runs the cook countdown on four BCD display digits and drives the magnetron enable and the end-of-cook beep.
- Owns the "+30 s" start semantics: quick start from idle, extend while cooking, clamp at 99:59.
- Sits between the front-panel input logic and the display/power drivers.

---
 rtl/microwave_pkg.sv | 71 +++++++
 rtl/microwave_cook_controller_if.sv | 25 ++
 rtl/button_edge_sync.sv | 23 ++
 rtl/microwave_cook_controller.sv | 162 ++++++++++++++++
 tb/tb_microwave_cook_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared types and time arithmetic for the microwave cook controller.
package microwave_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENTRY  = 3'd1,
      COOK   = 3'd2,
      PAUSED = 3'd3,
      DONE   = 3'd4
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t second_min;
      bcd_t first_min;
      bcd_t second_sec;
      bcd_t first_sec;
   } cook_time_t;

   localparam int unsigned MAX_TOTAL_SEC = 5999;

   // Total seconds of a (possibly unnormalised) mm:ss entry; 99:99 still fits 13 bits.
   function automatic logic [12:0] bcd_to_sec(input cook_time_t t);
      int unsigned sum;
      sum = 32'd600 * 32'(t.second_min) + 32'd60 * 32'(t.first_min)
          + 32'd10 * 32'(t.second_sec) + 32'(t.first_sec);
      return 13'(sum);
   endfunction

   // Clamp to 99:59 and split back into digits with seconds tens <= 5.
   function automatic cook_time_t sec_to_bcd(input logic [12:0] sec);
      int unsigned total;
      int unsigned mins;
      int unsigned secs;
      cook_time_t  t;
      total = 32'(sec);
      if (total > MAX_TOTAL_SEC) total = MAX_TOTAL_SEC;
      mins = total / 32'd60;
      secs = total % 32'd60;
      t.second_min = 4'(mins / 32'd10);
      t.first_min  = 4'(mins % 32'd10);
      t.second_sec = 4'(secs / 32'd10);
      t.first_sec  = 4'(secs % 32'd10);
      return t;
   endfunction

   // One-second BCD decrement with borrow; caller guarantees a nonzero time.
   function automatic cook_time_t bcd_dec(input cook_time_t t);
      cook_time_t r;
      r = t;
      if (t.first_sec != 4'd0) begin
         r.first_sec = t.first_sec - 4'd1;
      end else begin
         r.first_sec = 4'd9;
         if (t.second_sec != 4'd0) begin
            r.second_sec = t.second_sec - 4'd1;
         end else begin
            r.second_sec = 4'd5;
            if (t.first_min != 4'd0) begin
               r.first_min = t.first_min - 4'd1;
            end else begin
               r.first_min  = 4'd9;
               r.second_min = t.second_min - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/microwave_cook_controller_if.sv
// Front-panel inputs and display/power outputs of the cook controller.
interface microwave_cook_controller_if;
   logic       start_button;
   logic       stop_button;
   logic       door_open;
   logic       key_valid;
   logic [3:0] key_digit;
   logic [3:0] first_sec;
   logic [3:0] second_sec;
   logic [3:0] first_min;
   logic [3:0] second_min;
   logic       magnetron_on;
   logic       beep;
   logic [2:0] state;

   modport master (
      output start_button, stop_button, door_open, key_valid, key_digit,
      input  first_sec, second_sec, first_min, second_min, magnetron_on, beep, state
   );

   modport slave (
      input  start_button, stop_button, door_open, key_valid, key_digit,
      output first_sec, second_sec, first_min, second_min, magnetron_on, beep, state
   );
endinterface

// File: rtl/button_edge_sync.sv
// Single-flop synchroniser plus rising-edge detector for a level button.
module button_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic pulse
);
   logic sync_q;
   logic prev_q;

   // Capture the raw level, then remember last cycle's synced value.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= button;
         prev_q <= sync_q;
      end
   end

   assign pulse = sync_q & ~prev_q;
endmodule

// File: rtl/microwave_cook_controller.sv
// Cook sequencer: keypad entry, +30 s start, BCD countdown, pause, end beep.
module microwave_cook_controller
   import microwave_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50_000_000,
   parameter int unsigned QUICK_ADD_SEC = 30,
   parameter int unsigned BEEP_CYCLES   = 1000
) (
   input logic                         clk,
   input logic                         reset,
   microwave_cook_controller_if.slave  bus
);
   localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned BEEP_W  = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

   state_t             state_q, state_n;
   cook_time_t         time_q, time_n;
   logic [PRESC_W-1:0] presc_q, presc_n;
   logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_n;
   logic               beep_q, beep_n;
   logic               magnetron_q;
   logic               door_sync;
   logic               start_edge;
   logic               stop_edge;
   logic               key_ok;
   logic               tick;
   logic [12:0]        total;
   cook_time_t         dec_time;
   cook_time_t         quick_time;

   button_edge_sync u_start_sync (
      .clk    (clk),
      .reset  (reset),
      .button (bus.start_button),
      .pulse  (start_edge)
   );

   button_edge_sync u_stop_sync (
      .clk    (clk),
      .reset  (reset),
      .button (bus.stop_button),
      .pulse  (stop_edge)
   );

   // Door switch is acted on as a synchronised level.
   always_ff @(posedge clk) begin
      if (reset) door_sync <= 1'b0;
      else       door_sync <= bus.door_open;
   end

   // State, time, prescaler and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         time_q      <= '0;
         presc_q     <= '0;
         beep_cnt_q  <= '0;
         beep_q      <= 1'b0;
         magnetron_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         time_q      <= time_n;
         presc_q     <= presc_n;
         beep_cnt_q  <= beep_cnt_n;
         beep_q      <= beep_n;
         magnetron_q <= (state_n == COOK);
      end
   end

   // Next-state logic; each branch chain follows door > stop > start > key > tick.
   always_comb begin
      state_n    = state_q;
      time_n     = time_q;
      presc_n    = presc_q;
      beep_cnt_n = beep_cnt_q;
      beep_n     = beep_q;
      key_ok     = bus.key_valid && (bus.key_digit <= 4'd9);
      tick       = (presc_q == PRESC_W'(CLK_HZ - 1));
      total      = bcd_to_sec(time_q);
      dec_time   = bcd_dec(time_q);
      quick_time = sec_to_bcd(13'(QUICK_ADD_SEC));

      unique case (state_q)
         IDLE: begin
            if (stop_edge) begin
               time_n = '0;
            end else if (start_edge && !door_sync && total == 13'd0) begin
               state_n = COOK;
               time_n  = quick_time;
               presc_n = '0;
            end else if (key_ok) begin
               state_n = ENTRY;
               time_n  = cook_time_t'({time_q.first_min, time_q.second_sec,
                                       time_q.first_sec, bus.key_digit});
            end
         end
         ENTRY: begin
            if (stop_edge) begin
               state_n = IDLE;
               time_n  = '0;
            end else if (start_edge && !door_sync) begin
               state_n = COOK;
               time_n  = (total == 13'd0) ? quick_time : sec_to_bcd(total);
               presc_n = '0;
            end else if (key_ok) begin
               time_n  = cook_time_t'({time_q.first_min, time_q.second_sec,
                                       time_q.first_sec, bus.key_digit});
            end
         end
         COOK: begin
            if (door_sync || stop_edge) begin
               state_n = PAUSED;
            end else if (start_edge) begin
               time_n  = sec_to_bcd(total + 13'(QUICK_ADD_SEC));
               presc_n = '0;
            end else if (tick) begin
               presc_n = '0;
               time_n  = dec_time;
               if (dec_time == '0) begin
                  state_n    = DONE;
                  beep_n     = 1'b1;
                  beep_cnt_n = BEEP_W'(BEEP_CYCLES - 1);
               end
            end else begin
               presc_n = presc_q + 1'b1;
            end
         end
         PAUSED: begin
            if (stop_edge) begin
               state_n = IDLE;
               time_n  = '0;
            end else if (start_edge && !door_sync) begin
               state_n = COOK;
            end
         end
         DONE: begin
            if (door_sync || stop_edge || start_edge || bus.key_valid) begin
               state_n = IDLE;
               time_n  = '0;
               beep_n  = 1'b0;
            end else if (beep_cnt_q != '0) begin
               beep_cnt_n = beep_cnt_q - 1'b1;
            end else begin
               beep_n = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
            time_n  = '0;
            beep_n  = 1'b0;
         end
      endcase
   end

   assign bus.first_sec    = time_q.first_sec;
   assign bus.second_sec   = time_q.second_sec;
   assign bus.first_min    = time_q.first_min;
   assign bus.second_min   = time_q.second_min;
   assign bus.magnetron_on = magnetron_q;
   assign bus.beep         = beep_q;
   assign bus.state        = state_q;
endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed bench for microwave_cook_controller with CLK_HZ=10, BEEP_CYCLES=5.
module tb_microwave_cook_controller;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ENTRY  = 3'd1;
   localparam logic [2:0] ST_COOK   = 3'd2;
   localparam logic [2:0] ST_PAUSED = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam int NVEC = 23;

   typedef struct {
      logic        start;
      logic        stop;
      logic        door;
      logic        kv;
      logic [3:0]  key;
      logic [2:0]  st;
      logic [15:0] dig;
      logic        mag;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs [NVEC];

   microwave_cook_controller_if bus ();

   microwave_cook_controller #(
      .CLK_HZ        (10),
      .QUICK_ADD_SEC (30),
      .BEEP_CYCLES   (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(logic s, logic p, logic d, logic kv, logic [3:0] k,
                               logic [2:0] st, logic [15:0] dig, logic mag);
      vec_t v;
      v.start = s; v.stop = p; v.door = d; v.kv = kv; v.key = k;
      v.st = st; v.dig = dig; v.mag = mag;
      return v;
   endfunction

   task automatic check(input string name, input logic [2:0] st, input logic [15:0] dig,
                        input logic mag, input logic bp);
      logic [15:0] got;
      got = {bus.second_min, bus.first_min, bus.second_sec, bus.first_sec};
      checks++;
      if (bus.state !== st || got !== dig || bus.magnetron_on !== mag || bus.beep !== bp) begin
         errors++;
         $display("FAIL %s: got state=%0d time=%h mag=%b beep=%b, want state=%0d time=%h mag=%b beep=%b",
                  name, bus.state, got, bus.magnetron_on, bus.beep, st, dig, mag, bp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.start_button = 1'b0; bus.stop_button = 1'b0; bus.door_open = 1'b0;
      bus.key_valid = 1'b0; bus.key_digit = 4'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic press_key(input logic [3:0] d);
      @(negedge clk);
      bus.key_valid = 1'b1; bus.key_digit = d;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   // Returns just after the edge on which the FSM acts on the start edge.
   task automatic pulse_start();
      @(negedge clk);
      bus.start_button = 1'b1;
      @(negedge clk);
      bus.start_button = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int beeps;
      //                start stop door kv key   state      time     mag
      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  ST_ENTRY,  16'h0001, 1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  ST_ENTRY,  16'h0019, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  ST_ENTRY,  16'h0190, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, ST_ENTRY,  16'h0190, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  ST_ENTRY,  16'h0190, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_COOK,   16'h0230, 1'b1);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  ST_COOK,   16'h0230, 1'b1);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_PAUSED, 16'h0230, 1'b0);
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  ST_PAUSED, 16'h0230, 1'b0);
      vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  ST_PAUSED, 16'h0230, 1'b0);
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  ST_PAUSED, 16'h0230, 1'b0);
      vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  ST_PAUSED, 16'h0230, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_IDLE,   16'h0000, 1'b0);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd4,  ST_ENTRY,  16'h0004, 1'b0);
      vecs[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  ST_ENTRY,  16'h0004, 1'b0);
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_IDLE,   16'h0000, 1'b0);
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd10, ST_IDLE,   16'h0000, 1'b0);
      vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  ST_IDLE,   16'h0000, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_COOK,   16'h0030, 1'b1);
      vecs[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  ST_COOK,   16'h0030, 1'b1);
      vecs[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_PAUSED, 16'h0030, 1'b0);
      vecs[21] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  ST_PAUSED, 16'h0030, 1'b0);
      vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  ST_IDLE,   16'h0000, 1'b0);

      do_reset();
      #1;
      check("reset", ST_IDLE, 16'h0000, 1'b0, 1'b0);

      // Table: entry normalisation, pause/door/stop handling, stop beats start.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         bus.start_button = vecs[i].start;
         bus.stop_button  = vecs[i].stop;
         bus.door_open    = vecs[i].door;
         bus.key_valid    = vecs[i].kv;
         bus.key_digit    = vecs[i].key;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), vecs[i].st, vecs[i].dig, vecs[i].mag, 1'b0);
      end
      @(negedge clk);
      bus.start_button = 1'b0; bus.stop_button = 1'b0; bus.door_open = 1'b0; bus.key_valid = 1'b0;

      // Quick start to DONE and beep length.
      do_reset();
      pulse_start();
      check("quick_start", ST_COOK, 16'h0030, 1'b1, 1'b0);
      cycles(299);
      check("quick_last_sec", ST_COOK, 16'h0001, 1'b1, 1'b0);
      cycles(1);
      check("quick_done", ST_DONE, 16'h0000, 1'b0, 1'b1);
      beeps = 1;
      for (int i = 0; i < 9; i++) begin
         cycles(1);
         if (bus.beep === 1'b1) beeps++;
      end
      checks++;
      if (beeps != 5) begin
         errors++;
         $display("FAIL beep_len: got %0d cycles, want 5", beeps);
      end
      check("done_hold", ST_DONE, 16'h0000, 1'b0, 1'b0);
      press_key(4'd3);
      check("done_key_exit", ST_IDLE, 16'h0000, 1'b0, 1'b0);

      // Normalised entry and minute borrow.
      do_reset();
      press_key(4'd1); press_key(4'd9); press_key(4'd0);
      pulse_start();
      check("norm_start", ST_COOK, 16'h0230, 1'b1, 1'b0);
      cycles(9);
      check("norm_pre_tick", ST_COOK, 16'h0230, 1'b1, 1'b0);
      cycles(1);
      check("norm_tick", ST_COOK, 16'h0229, 1'b1, 1'b0);
      cycles(300);
      check("norm_borrow", ST_COOK, 16'h0159, 1'b1, 1'b0);

      // Extend with clamp, and plain extend.
      do_reset();
      press_key(4'd9); press_key(4'd9); press_key(4'd4); press_key(4'd5);
      pulse_start();
      check("clamp_start", ST_COOK, 16'h9945, 1'b1, 1'b0);
      pulse_start();
      check("clamp_extend", ST_COOK, 16'h9959, 1'b1, 1'b0);
      do_reset();
      press_key(4'd5); press_key(4'd0); press_key(4'd0);
      pulse_start();
      check("ext_start", ST_COOK, 16'h0500, 1'b1, 1'b0);
      pulse_start();
      check("ext_extend", ST_COOK, 16'h0530, 1'b1, 1'b0);

      // Door safety and prescaler resume.
      do_reset();
      pulse_start();
      cycles(100);
      check("door_at_20", ST_COOK, 16'h0020, 1'b1, 1'b0);
      @(negedge clk);
      bus.door_open = 1'b1;
      cycles(2);
      check("door_pause", ST_PAUSED, 16'h0020, 1'b0, 1'b0);
      cycles(30);
      check("door_frozen", ST_PAUSED, 16'h0020, 1'b0, 1'b0);
      pulse_start();
      check("door_start_ignored", ST_PAUSED, 16'h0020, 1'b0, 1'b0);
      @(negedge clk);
      bus.door_open = 1'b0;
      bus.start_button = 1'b1;
      @(negedge clk);
      bus.start_button = 1'b0;
      @(posedge clk); #1;
      check("door_resume", ST_COOK, 16'h0020, 1'b1, 1'b0);
      cycles(8);
      check("resume_pre_tick", ST_COOK, 16'h0020, 1'b1, 1'b0);
      cycles(1);
      check("resume_tick", ST_COOK, 16'h0019, 1'b1, 1'b0);

      // Reset while cooking.
      do_reset();
      press_key(4'd1); press_key(4'd1); press_key(4'd0);
      pulse_start();
      check("rst_cook", ST_COOK, 16'h0110, 1'b1, 1'b0);
      cycles(3);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_cook", ST_IDLE, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
